vx_gpr_slice: RTL and testbench

- Register-file slice for one issue slot.
- Slave side of the GPR request/response handshake driven by the operand collector: it accepts one source-operand read per cycle and returns a full SIMD-lane row one cycle later.
- Has a masked writeback port from the commit stage.
- Self-clears its storage after reset before accepting any traffic.

---
 rtl/VX_gpu_pkg.sv | 47 ++++
 rtl/vx_gpr_ram_1r1w.sv | 40 ++++
 rtl/vx_gpr_slice.sv | 150 +++++++++++++++
 tb/tb_vx_gpr_slice.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared GPU configuration for the GPR slice: geometry, widths, FSM state
// type and the {wis, sid, reg} row-index struct with its flat-address helper.
package VX_gpu_pkg;

  localparam int NUM_WIS      = 4;
  localparam int SIMD_COUNT   = 1;
  localparam int NUM_SREGS    = 64;
  localparam int SIMD_WIDTH   = 4;
  localparam int XLEN         = 32;
  localparam int NUM_SRC_OPDS = 3;

  localparam int ISSUE_WIS_W   = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1;
  localparam int SIMD_IDX_W    = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int NR_S_BITS     = $clog2(NUM_SREGS);
  localparam int SRC_OPD_WIDTH = (NUM_SRC_OPDS > 1) ? $clog2(NUM_SRC_OPDS) : 1;
  localparam int ROW_W         = SIMD_WIDTH * XLEN;

  function automatic int gpr_slice_depth(input int wis, input int simd, input int sregs);
    return wis * simd * sregs;
  endfunction

  localparam int GPR_SLICE_DEPTH = gpr_slice_depth(NUM_WIS, SIMD_COUNT, NUM_SREGS);
  localparam int GPR_ROW_IDX_W   = $clog2(GPR_SLICE_DEPTH);

  typedef enum logic {
    INIT,
    READY
  } gpr_slice_state_e;

  typedef struct packed {
    logic [ISSUE_WIS_W-1:0] wis;
    logic [SIMD_IDX_W-1:0]  sid;
    logic [NR_S_BITS-1:0]   reg_id;
  } gpr_row_idx_t;

  typedef logic [SIMD_WIDTH-1:0][XLEN-1:0] gpr_row_t;

  // Dense row address; the one-bit sid field is unused when SIMD_COUNT is 1.
  function automatic logic [GPR_ROW_IDX_W-1:0] gpr_row_addr(input gpr_row_idx_t idx);
    int flat;
    flat = int'(idx.wis) * SIMD_COUNT;
    if (SIMD_COUNT > 1) flat = flat + int'(idx.sid);
    flat = flat * NUM_SREGS + int'(idx.reg_id);
    return flat[GPR_ROW_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/vx_gpr_ram_1r1w.sv
// One-read/one-write synchronous row RAM with per-lane write enables and a
// registered, read-old read port.
module vx_gpr_ram_1r1w #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [LANES-1:0][LANE_W-1:0] rd_data,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [LANES-1:0]             wr_mask,
  input  logic [LANES-1:0][LANE_W-1:0] wr_data
);

  // NOTE: the storage array has no reset; the owner clears it row by row.
  logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) mem[wr_addr][i] <= wr_data[i];
      end
    end
  end

  // NOTE: both ports update with <=, so a same-edge read samples the pre-write row.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vx_gpr_slice.sv
// GPR slice for one issue slot: clears its RAM after reset, then serves one
// row read per cycle plus a masked writeback. VX_GPR_WB_BYPASS_EN enables write-first merge.
module vx_gpr_slice
  import VX_gpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SRC_OPD_WIDTH-1:0] req_opd_id,
  input  logic [SIMD_IDX_W-1:0]    req_sid,
  input  logic [ISSUE_WIS_W-1:0]   req_wis,
  input  logic [NR_S_BITS-1:0]     req_reg_id,
  output logic                     rsp_valid,
  output logic [SRC_OPD_WIDTH-1:0] rsp_opd_id,
  output logic [ROW_W-1:0]         rsp_data,
  input  logic                     wb_valid,
  input  logic [ISSUE_WIS_W-1:0]   wb_wis,
  input  logic [SIMD_IDX_W-1:0]    wb_sid,
  input  logic [NR_S_BITS-1:0]     wb_rd,
  input  logic [SIMD_WIDTH-1:0]    wb_tmask,
  input  logic [ROW_W-1:0]         wb_data,
  output logic                     init_done
);

  localparam logic [GPR_ROW_IDX_W-1:0] LAST_ROW = GPR_ROW_IDX_W'(GPR_SLICE_DEPTH - 1);

  gpr_slice_state_e           state_q, state_d;
  logic [GPR_ROW_IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  gpr_row_idx_t               rd_idx, wb_idx;
  logic [GPR_ROW_IDX_W-1:0]   rd_row, wb_row;
  logic                       fire, wb_commit;
  logic                       ram_wr_en;
  logic [GPR_ROW_IDX_W-1:0]   ram_wr_addr;
  logic [SIMD_WIDTH-1:0]      ram_wr_mask;
  gpr_row_t                   ram_wr_data, ram_rd_data, rsp_row;
  logic                       rd_zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + GPR_ROW_IDX_W'(1);
        if (clr_cnt_q == LAST_ROW) state_d = READY;
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == READY);
  assign init_done = (state_q == READY);
  assign fire      = req_valid && req_ready;

  assign rd_idx    = '{wis: req_wis, sid: req_sid, reg_id: req_reg_id};
  assign wb_idx    = '{wis: wb_wis, sid: wb_sid, reg_id: wb_rd};
  assign rd_row    = gpr_row_addr(rd_idx);
  assign wb_row    = gpr_row_addr(wb_idx);
  assign wb_commit = wb_valid && (state_q == READY) && (wb_rd != '0);

  // The clear sequencer owns the write port until the slice is READY.
  always_comb begin
    ram_wr_en   = wb_commit;
    ram_wr_addr = wb_row;
    ram_wr_mask = wb_tmask;
    ram_wr_data = wb_data;
    if (state_q == INIT) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = clr_cnt_q;
      ram_wr_mask = '1;
      ram_wr_data = '0;
    end
  end

  vx_gpr_ram_1r1w #(
    .DEPTH  (GPR_SLICE_DEPTH),
    .ADDR_W (GPR_ROW_IDX_W),
    .LANES  (SIMD_WIDTH),
    .LANE_W (XLEN)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (fire),
    .rd_addr (rd_row),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_mask (ram_wr_mask),
    .wr_data (ram_wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_opd_id <= '0;
      rd_zero_q  <= 1'b0;
    end else begin
      rsp_valid <= fire;
      if (fire) begin
        rsp_opd_id <= req_opd_id;
        rd_zero_q  <= (req_reg_id == '0);
      end
    end
  end

`ifdef VX_GPR_WB_BYPASS_EN
  logic [SIMD_WIDTH-1:0] byp_mask_q;
  gpr_row_t              byp_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else if (fire) begin
      byp_mask_q <= (wb_commit && (wb_row == rd_row)) ? wb_tmask : '0;
      byp_data_q <= wb_data;
    end
  end

  always_comb begin
    rsp_row = ram_rd_data;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      if (byp_mask_q[i]) rsp_row[i] = byp_data_q[i];
    end
    if (rd_zero_q) rsp_row = '0;
  end
`else
  always_comb begin
    rsp_row = ram_rd_data;
    if (rd_zero_q) rsp_row = '0;
  end
`endif

  assign rsp_data = rsp_row;

  wb_during_init_a: assert property (@(posedge clk) disable iff (reset)
    !(wb_valid && (state_q == INIT)));

endmodule

// File: tb/tb_vx_gpr_slice.sv
// Self-checking bench for vx_gpr_slice: table-driven write/read vectors plus
// sequences for init, back-to-back, collision and mid-operation reset.
module tb_vx_gpr_slice;
  import VX_gpu_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req_valid;
  logic                     req_ready;
  logic [SRC_OPD_WIDTH-1:0] req_opd_id;
  logic [SIMD_IDX_W-1:0]    req_sid;
  logic [ISSUE_WIS_W-1:0]   req_wis;
  logic [NR_S_BITS-1:0]     req_reg_id;
  logic                     rsp_valid;
  logic [SRC_OPD_WIDTH-1:0] rsp_opd_id;
  logic [ROW_W-1:0]         rsp_data;
  logic                     wb_valid;
  logic [ISSUE_WIS_W-1:0]   wb_wis;
  logic [SIMD_IDX_W-1:0]    wb_sid;
  logic [NR_S_BITS-1:0]     wb_rd;
  logic [SIMD_WIDTH-1:0]    wb_tmask;
  logic [ROW_W-1:0]         wb_data;
  logic                     init_done;

  vx_gpr_slice dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opd_id (req_opd_id),
    .req_sid    (req_sid),
    .req_wis    (req_wis),
    .req_reg_id (req_reg_id),
    .rsp_valid  (rsp_valid),
    .rsp_opd_id (rsp_opd_id),
    .rsp_data   (rsp_data),
    .wb_valid   (wb_valid),
    .wb_wis     (wb_wis),
    .wb_sid     (wb_sid),
    .wb_rd      (wb_rd),
    .wb_tmask   (wb_tmask),
    .wb_data    (wb_data),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SRC_OPD_WIDTH-1:0] opd;
    logic [ROW_W-1:0]         data;
  } exp_t;

  typedef struct {
    logic [ISSUE_WIS_W-1:0]   wis;
    logic [NR_S_BITS-1:0]     rg;
    logic [SIMD_WIDTH-1:0]    mask;
    logic [ROW_W-1:0]         wdata;
    logic [SRC_OPD_WIDTH-1:0] opd;
    logic [ROW_W-1:0]         exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;
  logic [ROW_W-1:0] last_row;

  function automatic logic [ROW_W-1:0] row4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Response scoreboard: expectations are queued when a read is driven.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", ROW_W'(rsp_valid), '0);
      end else begin
        e = sb.pop_front();
        check("rsp_opd", ROW_W'(rsp_opd_id), ROW_W'(e.opd));
        check("rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic wb_only(input logic [ISSUE_WIS_W-1:0] wis, input logic [NR_S_BITS-1:0] rg,
                         input logic [SIMD_WIDTH-1:0] m, input logic [ROW_W-1:0] d);
    wb_valid = 1'b1; wb_wis = wis; wb_sid = '0; wb_rd = rg; wb_tmask = m; wb_data = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic rd_only(input logic [ISSUE_WIS_W-1:0] wis, input logic [NR_S_BITS-1:0] rg,
                         input logic [SRC_OPD_WIDTH-1:0] opd, input logic [ROW_W-1:0] exp);
    req_valid = 1'b1; req_wis = wis; req_sid = '0; req_reg_id = rg; req_opd_id = opd;
    sb.push_back('{opd: opd, data: exp});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rd_wb(input logic [ISSUE_WIS_W-1:0] wis, input logic [NR_S_BITS-1:0] rg,
                       input logic [SRC_OPD_WIDTH-1:0] opd, input logic [SIMD_WIDTH-1:0] m,
                       input logic [ROW_W-1:0] d, input logic [ROW_W-1:0] exp);
    req_valid = 1'b1; req_wis = wis; req_sid = '0; req_reg_id = rg; req_opd_id = opd;
    wb_valid = 1'b1; wb_wis = wis; wb_sid = '0; wb_rd = rg; wb_tmask = m; wb_data = d;
    sb.push_back('{opd: opd, data: exp});
    @(posedge clk); #1;
    req_valid = 1'b0;
    wb_valid  = 1'b0;
  endtask

  // Returns the number of not-ready cycles seen before req_ready rose.
  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      n++;
      if (n >= 2000) begin
        $display("FAIL init_timeout: req_ready still low after %0d cycles", n);
        $fatal(1);
      end
    end
  endtask

  int n;

  initial begin
    vecs[0] = '{wis: 1, rg: 5,  mask: 4'b0101, wdata: row4(32'h11, 32'h22, 32'h33, 32'h44),
                opd: 2, exp: row4(32'h11, 32'h0, 32'h33, 32'h0)};
    vecs[1] = '{wis: 0, rg: 1,  mask: 4'b1111, wdata: row4(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004),
                opd: 0, exp: row4(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004)};
    vecs[2] = '{wis: 3, rg: 63, mask: 4'b1000, wdata: row4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
                opd: 1, exp: row4(32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF)};
    vecs[3] = '{wis: 2, rg: 0,  mask: 4'b1111, wdata: row4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
                opd: 2, exp: '0};
    vecs[4] = '{wis: 2, rg: 33, mask: 4'b0000, wdata: row4(32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888),
                opd: 1, exp: '0};
    vecs[5] = '{wis: 0, rg: 2,  mask: 4'b0110, wdata: row4(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hCAFE_F00D),
                opd: 0, exp: row4(32'h0, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h0)};

    reset = 1'b1;
    req_valid = 1'b0; req_opd_id = '0; req_sid = '0; req_wis = '0; req_reg_id = '0;
    wb_valid = 1'b0; wb_wis = '0; wb_sid = '0; wb_rd = '0; wb_tmask = '0; wb_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", ROW_W'(req_ready), '0);
    check("reset_rsp_valid", ROW_W'(rsp_valid), '0);
    check("reset_rsp_opd", ROW_W'(rsp_opd_id), '0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_init_done", ROW_W'(init_done), '0);

    // Init clear: request held from the first cycle out of reset.
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b1; req_wis = 2'd3; req_sid = '0; req_reg_id = 6'd63; req_opd_id = 2'd1;
    wait_ready(n);
    check("init_cycles", ROW_W'(n), ROW_W'(256));
    check("init_done_high", ROW_W'(init_done), ROW_W'(1));
    sb.push_back('{opd: 2'd1, data: '0});
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Write then read, one table entry per pair.
    for (int i = 0; i < 6; i++) begin
      wb_only(vecs[i].wis, vecs[i].rg, vecs[i].mask, vecs[i].wdata);
      rd_only(vecs[i].wis, vecs[i].rg, vecs[i].opd, vecs[i].exp);
    end

    // Back-to-back reads with tags 0,1,2.
    wb_only(2'd2, 6'd7, 4'hF, row4(32'h70, 32'h70, 32'h70, 32'h70));
    wb_only(2'd2, 6'd8, 4'hF, row4(32'h80, 32'h80, 32'h80, 32'h80));
    wb_only(2'd2, 6'd9, 4'hF, row4(32'h90, 32'h90, 32'h90, 32'h90));
    rd_only(2'd2, 6'd7, 2'd0, row4(32'h70, 32'h70, 32'h70, 32'h70));
    rd_only(2'd2, 6'd8, 2'd1, row4(32'h80, 32'h80, 32'h80, 32'h80));
    rd_only(2'd2, 6'd9, 2'd2, row4(32'h90, 32'h90, 32'h90, 32'h90));
    @(posedge clk); #1;
    @(negedge clk);
    last_row = row4(32'h90, 32'h90, 32'h90, 32'h90);
    check("idle_rsp_valid", ROW_W'(rsp_valid), '0);
    check("idle_rsp_hold", rsp_data, last_row);
    @(posedge clk); #1;

    // Same-cycle read and partial write to one row.
    wb_only(2'd0, 6'd10, 4'hF, row4(32'hAA, 32'hAA, 32'hAA, 32'hAA));
`ifdef VX_GPR_WB_BYPASS_EN
    rd_wb(2'd0, 6'd10, 2'd1, 4'b0011, row4(32'hBB, 32'hBB, 32'hBB, 32'hBB),
          row4(32'hBB, 32'hBB, 32'hAA, 32'hAA));
`else
    rd_wb(2'd0, 6'd10, 2'd1, 4'b0011, row4(32'hBB, 32'hBB, 32'hBB, 32'hBB),
          row4(32'hAA, 32'hAA, 32'hAA, 32'hAA));
`endif
    rd_only(2'd0, 6'd10, 2'd2, row4(32'hBB, 32'hBB, 32'hAA, 32'hAA));

    // Mid-operation reset right after a read fires; storage must be cleared again.
    wb_only(2'd1, 6'd20, 4'hF, row4(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004));
    rd_only(2'd1, 6'd20, 2'd1, row4(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004));
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_rsp_valid", ROW_W'(rsp_valid), '0);
    check("midrst_init_done", ROW_W'(init_done), '0);
    check("midrst_req_ready", ROW_W'(req_ready), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(n);
    check("reinit_cycles", ROW_W'(n), ROW_W'(256));
    @(posedge clk); #1;
    rd_only(2'd1, 6'd20, 2'd0, '0);
    rd_only(2'd1, 6'd5, 2'd2, '0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", ROW_W'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
